// File: rtl/sid_filter_mc.sv
// sid_filter_mc
// Time-multiplexed SID state-variable filter. One shared signed 16x16
// multiplier serves CHANNELS independent filter state sets; each accepted
// request runs one filter update (BP, LP, HP) followed by volume mixing (MIX)
// and reports the result with a one-cycle done pulse. Results saturate.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, ch         request pulse (sampled only in IDLE) and channel index
//   w0, q_inv         signed cutoff coefficient, unsigned 1/Q << 8
//   vi, vd            signed filter input sum, signed direct-path sum
//   mode, vol         output select {hp, bp, lp}, master volume
//   busy, done        sequence in progress, result valid pulse
//   vlp_o/vbp_o/vhp_o updated state of the served channel
//   audio_o           volume-scaled mixer output
module sid_filter_mc #(
    parameter int  CHANNELS = 4,
    parameter int  DATA_W   = 24,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CH_W-1:0]          ch,
    input  logic signed [15:0]       w0,
    input  logic [8:0]               q_inv,
    input  logic signed [DATA_W-1:0] vi,
    input  logic signed [DATA_W-1:0] vd,
    input  logic [2:0]               mode,
    input  logic [3:0]               vol,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] vlp_o,
    output logic signed [DATA_W-1:0] vbp_o,
    output logic signed [DATA_W-1:0] vhp_o,
    output logic signed [DATA_W-1:0] audio_o
);

    localparam int S  = DATA_W - 16;
    localparam int SH = 33 - DATA_W;
    // Working width large enough for q_inv*hi(x) minus two DATA_W terms
    // and for the four-term mixer sum.
    localparam int WW = DATA_W + 18;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_BP   = 3'd1;
    localparam logic [2:0] ST_LP   = 3'd2;
    localparam logic [2:0] ST_HP   = 3'd3;
    localparam logic [2:0] ST_MIX  = 3'd4;

    localparam int unsigned CHN = CHANNELS;
    localparam logic [CH_W:0] CH_LIMIT = CHN[CH_W:0];

    localparam logic signed [WW-1:0] D_MAX   = {{(WW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [WW-1:0] D_MIN   = {{(WW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [WW-1:0] A16_MAX = {{(WW-15){1'b0}}, {15{1'b1}}};
    localparam logic signed [WW-1:0] A16_MIN = {{(WW-15){1'b1}}, {15{1'b0}}};

    function automatic logic signed [WW-1:0] ext(input logic signed [DATA_W-1:0] x);
        return {{(WW-DATA_W){x[DATA_W-1]}}, x};
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [WW-1:0] x);
        logic signed [WW-1:0] y;
        if (x > D_MAX) begin
            y = D_MAX;
        end else if (x < D_MIN) begin
            y = D_MIN;
        end else begin
            y = x;
        end
        return y[DATA_W-1:0];
    endfunction

    logic [2:0]               state_q, state_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     accept;
    logic [CH_W-1:0]          ch_q;
    logic signed [15:0]       w0_q;
    logic [8:0]               qInv_q;
    logic signed [DATA_W-1:0] vi_q, vd_q;
    logic [2:0]               mode_q;
    logic [3:0]               vol_q;
    logic signed [DATA_W-1:0] vbpNew_q, vlpNew_q, vhpNew_q;
    logic signed [DATA_W-1:0] vlpMem_q [CHANNELS];
    logic signed [DATA_W-1:0] vbpMem_q [CHANNELS];
    logic signed [DATA_W-1:0] vhpMem_q [CHANNELS];

    logic signed [15:0]       mulA, mulB;
    logic signed [31:0]       product;
    logic signed [WW-1:0]     prodWide, shiftedProd;
    logic signed [WW-1:0]     bpSum, lpSum, hpSum;
    logic signed [WW-1:0]     amix, ampShift;
    logic signed [15:0]       a16;

    assign busy = busy_q;
    assign done = done_q;

    // Sequencer: a request is taken only in IDLE and only for an existing
    // channel. busy stays high through the done cycle; a request accepted
    // in that cycle keeps it high without a gap.
    always_comb begin
        accept  = (state_q == ST_IDLE) && start && ({1'b0, ch} < CH_LIMIT);
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BP;
            ST_BP:   state_d = ST_LP;
            ST_LP:   state_d = ST_HP;
            ST_HP:   state_d = ST_MIX;
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_q == ST_MIX);
        busy_d = (state_d != ST_IDLE) || done_d;
    end

    // Operand selection for the single shared multiplier. The mixer sum is
    // reduced to 16 bits with clamping before it is scaled by the volume.
    always_comb begin
        amix = ext(vd_q);
        if (mode_q[0]) amix = amix + ext(vlpNew_q);
        if (mode_q[1]) amix = amix + ext(vbpNew_q);
        if (mode_q[2]) amix = amix + ext(vhpNew_q);
        ampShift = amix >>> S;
        if (ampShift > A16_MAX) begin
            a16 = 16'sh7fff;
        end else if (ampShift < A16_MIN) begin
            a16 = 16'sh8000;
        end else begin
            a16 = ampShift[15:0];
        end

        mulA = '0;
        mulB = '0;
        case (state_q)
            ST_BP: begin
                mulA = w0_q;
                mulB = vhpMem_q[ch_q][DATA_W-1:S];
            end
            ST_LP: begin
                mulA = w0_q;
                mulB = vbpMem_q[ch_q][DATA_W-1:S];
            end
            ST_HP: begin
                mulA = {7'b0, qInv_q};
                mulB = vbpNew_q[DATA_W-1:S];
            end
            ST_MIX: begin
                mulA = {8'b0, vol_q, 4'b0};
                mulB = a16;
            end
            default: ;
        endcase
    end

    assign product     = mulA * mulB;
    assign prodWide    = {{(WW-32){product[31]}}, product};
    assign shiftedProd = prodWide >>> SH;
    // BP and LP both read the stored (old) state; only HP sees the new values.
    assign bpSum       = ext(vbpMem_q[ch_q]) - shiftedProd;
    assign lpSum       = ext(vlpMem_q[ch_q]) - shiftedProd;
    assign hpSum       = prodWide - ext(vlpNew_q) - ext(vi_q);

    // Request capture, per-step result registers, and writeback of the new
    // channel state and outputs at the end of the MIX cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ch_q     <= '0;
            w0_q     <= '0;
            qInv_q   <= '0;
            vi_q     <= '0;
            vd_q     <= '0;
            mode_q   <= '0;
            vol_q    <= '0;
            vbpNew_q <= '0;
            vlpNew_q <= '0;
            vhpNew_q <= '0;
            vlp_o    <= '0;
            vbp_o    <= '0;
            vhp_o    <= '0;
            audio_o  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                vlpMem_q[i] <= '0;
                vbpMem_q[i] <= '0;
                vhpMem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (accept) begin
                ch_q   <= ch;
                w0_q   <= w0;
                qInv_q <= q_inv;
                vi_q   <= vi;
                vd_q   <= vd;
                mode_q <= mode;
                vol_q  <= vol;
            end
            case (state_q)
                ST_BP:  vbpNew_q <= sat(bpSum);
                ST_LP:  vlpNew_q <= sat(lpSum);
                ST_HP:  vhpNew_q <= sat(hpSum);
                ST_MIX: begin
                    vlpMem_q[ch_q] <= vlpNew_q;
                    vbpMem_q[ch_q] <= vbpNew_q;
                    vhpMem_q[ch_q] <= vhpNew_q;
                    vlp_o          <= vlpNew_q;
                    vbp_o          <= vbpNew_q;
                    vhp_o          <= vhpNew_q;
                    audio_o        <= sat(prodWide);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sid_filter_mc.sv
// tb_sid_filter_mc
// Self-checking bench for sid_filter_mc (3 channels, 24-bit data). Requests
// are compared against a per-channel arithmetic model of the filter equations.
module tb_sid_filter_mc;

    localparam int CHANNELS = 3;
    localparam int DATA_W   = 24;
    localparam int CH_W     = 2;
    localparam int S        = DATA_W - 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [CH_W-1:0]          ch;
    logic signed [15:0]       w0;
    logic [8:0]               q_inv;
    logic signed [DATA_W-1:0] vi, vd;
    logic [2:0]               mode;
    logic [3:0]               vol;
    logic                     busy, done;
    logic signed [DATA_W-1:0] vlp_o, vbp_o, vhp_o, audio_o;

    int errorCount = 0;
    int checkCount = 0;

    longint mLp [CHANNELS];
    longint mBp [CHANNELS];
    longint mHp [CHANNELS];
    longint expLp, expBp, expHp, expAudio;

    sid_filter_mc #(.CHANNELS(CHANNELS), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .ch(ch), .w0(w0), .q_inv(q_inv),
        .vi(vi), .vd(vd), .mode(mode), .vol(vol), .busy(busy), .done(done),
        .vlp_o(vlp_o), .vbp_o(vbp_o), .vhp_o(vhp_o), .audio_o(audio_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint satD(input longint x);
        longint lim;
        lim = longint'(1) <<< (DATA_W - 1);
        if (x > lim - 1) return lim - 1;
        if (x < -lim) return -lim;
        return x;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < CHANNELS; i++) begin
            mLp[i] = 0;
            mBp[i] = 0;
            mHp[i] = 0;
        end
        expLp = 0; expBp = 0; expHp = 0; expAudio = 0;
    endtask

    // Filter equations evaluated directly with 64-bit integers.
    task automatic modelUpdate(input int c, input longint w, input longint q, input longint vIn,
                               input longint vDir, input int md, input int vl);
        longint bpN, lpN, hpN, amix, a16;
        bpN = satD(mBp[c] - ((w * (mHp[c] >>> S)) >>> (33 - DATA_W)));
        lpN = satD(mLp[c] - ((w * (mBp[c] >>> S)) >>> (33 - DATA_W)));
        hpN = satD(q * (bpN >>> S) - lpN - vIn);
        amix = vDir;
        if ((md & 1) != 0) amix += lpN;
        if ((md & 2) != 0) amix += bpN;
        if ((md & 4) != 0) amix += hpN;
        a16 = amix >>> S;
        if (a16 > 32767) a16 = 32767;
        if (a16 < -32768) a16 = -32768;
        mLp[c] = lpN; mBp[c] = bpN; mHp[c] = hpN;
        expLp = lpN; expBp = bpN; expHp = hpN;
        expAudio = satD(longint'(vl) * 16 * a16);
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "Vlp"}, vlp_o, expLp);
        checkOutput({tag, "Vbp"}, vbp_o, expBp);
        checkOutput({tag, "Vhp"}, vhp_o, expHp);
        checkOutput({tag, "Audio"}, audio_o, expAudio);
    endtask

    // Issues one request, scrambles the inputs after the accepting edge,
    // pokes start while busy, then waits (bounded) for done and checks.
    task automatic applyStimulus(input int c, input int w, input int q, input longint vIn,
                                 input longint vDir, input int md, input int vl);
        longint wS, qS, viS, vdS;
        int doneAt, busyCnt;
        @(negedge clk);
        start = 1'b1;
        ch    = c[CH_W-1:0];
        w0    = w[15:0];
        q_inv = q[8:0];
        vi    = vIn[DATA_W-1:0];
        vd    = vDir[DATA_W-1:0];
        mode  = md[2:0];
        vol   = vl[3:0];
        wS = longint'(w0); qS = longint'(q_inv); viS = longint'(vi); vdS = longint'(vd);
        doneAt = 0;
        busyCnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                ch    = CH_W'($urandom);
                w0    = 16'($urandom);
                q_inv = 9'($urandom);
                vi    = DATA_W'($urandom);
                vd    = DATA_W'($urandom);
                mode  = 3'($urandom);
                vol   = 4'($urandom);
            end
            if (k == 2) begin
                start = 1'b1;
                ch    = '0;
            end
            if (k == 3) start = 1'b0;
            if (busy) busyCnt++;
            if (done) begin
                doneAt = k;
                break;
            end
        end
        checkOutput("doneLatency", doneAt, 5);
        checkOutput("busyCycles", busyCnt, 5);
        modelUpdate(c, wS, qS, viS, vdS, md, vl);
        checkState("req");
    endtask

    initial begin
        int nDone, activity;
        modelReset();
        rst = 1'b1; start = 1'b0; ch = '0; w0 = '0; q_inv = '0;
        vi = '0; vd = '0; mode = '0; vol = '0;
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkState("rst");
        rst = 1'b0;

        // Directed sequence
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1000, 256, 65536, 0, 4, 15);
        checkOutput("tp1Vbp", vbp_o, 0);
        checkOutput("tp1Vlp", vlp_o, 0);
        checkOutput("tp1Vhp", vhp_o, -65536);
        checkOutput("tp1Audio", audio_o, -61440);
        applyStimulus(0, 1000, 256, 65536, 0, 4, 15);
        checkOutput("tp2Vbp", vbp_o, 500);
        checkOutput("tp2Vlp", vlp_o, 0);
        checkOutput("tp2Vhp", vhp_o, -65280);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("isoCh1Vhp", vhp_o, 0);
        applyStimulus(0, 1000, 256, 65536, 0, 4, 15);
        applyStimulus(2, 0, 0, -8388608, 0, 0, 0);
        checkOutput("satVhp", vhp_o, 8388607);

        // Invalid channel: no activity, outputs hold
        @(negedge clk);
        start = 1'b1;
        ch    = CH_W'(CHANNELS);
        w0    = 16'sd999; q_inv = 9'd100; vi = 24'sd12345; vd = 24'sd777;
        mode  = 3'b111; vol = 4'd15;
        activity = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy || done) activity++;
        end
        checkOutput("invalidActivity", activity, 0);
        checkState("hold");

        // start held high: back-to-back sequences every 5 cycles
        @(negedge clk);
        start = 1'b1; ch = '0; w0 = 16'sd3000; q_inv = 9'd300;
        vi = 24'sd20000; vd = -24'sd5000; mode = 3'b111; vol = 4'd9;
        nDone = 0;
        for (int k = 1; k <= 20 && nDone < 3; k++) begin
            @(negedge clk);
            if (k == 11) start = 1'b0;
            if (done) begin
                nDone++;
                checkOutput("b2bDoneAt", k, 5 * nDone);
                modelUpdate(0, 3000, 300, 20000, -5000, 7, 9);
                checkState("b2b");
            end
        end
        checkOutput("b2bDoneCount", nDone, 3);

        // Reset during LP aborts the sequence and clears all state
        @(negedge clk);
        start = 1'b1; ch = '0; w0 = 16'sd1234; q_inv = 9'd100;
        vi = 24'sd777; vd = '0; mode = 3'b001; vol = 4'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        checkOutput("midRstBusy", busy, 0);
        checkState("midRst");
        activity = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) activity++;
        end
        checkOutput("midRstNoDone", activity, 0);
        applyStimulus(0, 0, 0, 0, 0, 7, 15);
        checkOutput("midRstQueryVbp", vbp_o, 0);

        // Randomized requests
        for (int n = 0; n < 40; n++) begin
            int c, w, q, md, vl;
            logic signed [DATA_W-1:0] rvi, rvd;
            c   = int'($urandom_range(CHANNELS - 1, 0));
            w   = int'($urandom_range(65535, 0)) - 32768;
            q   = int'($urandom_range(511, 0));
            rvi = DATA_W'($urandom);
            rvd = DATA_W'($urandom);
            if ((n % 2) == 1) begin
                rvi = rvi >>> 6;
                rvd = rvd >>> 6;
            end
            md  = int'($urandom_range(7, 0));
            vl  = int'($urandom_range(15, 0));
            if ((n % 8) == 7) vl = 0;
            applyStimulus(c, w, q, longint'(rvi), longint'(rvd), md, vl);
            if (vl == 0) checkOutput("vol0Audio", audio_o, 0);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
